seg_bus_capture: RTL and testbench

- Receive-side companion to the team's nibble-to-seven-segment encoder.
- Monitors a multiplexed seven-segment display bus (segment lines plus one-hot digit select) and recovers the nibble shown on each digit.
- Captures a pattern only after it has been stable, decodes it through the inverse of the shared segment code table, and flags patterns that are unknown or ambiguous.
- Sits in verification/self-check and loopback paths next to the display driver.

---
 rtl/seg_pkg.sv | 29 ++
 rtl/seg_pattern_decode.sv | 26 ++
 rtl/seg_bus_capture.sv | 150 +++++++++++++++
 tb/tb_seg_bus_capture.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment code table and helpers for the segment bus capture block.
package seg_pkg;

  localparam int SEG_W = 7;
  localparam int NIB_W = 4;

  // Same equations as the display encoder; nibbles 0 and 8 share the all-on pattern.
  localparam logic [SEG_W-1:0] SEG_CODE [0:15] = '{
    7'b1111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1001010, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b0010101
  };

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} fsm_state_t;

  function automatic logic onehot_legal(input logic [7:0] sel);
    return (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);
  endfunction

  function automatic logic [2:0] sel_index(input logic [7:0] sel);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 0; k < 8; k++)
      if (sel[k]) idx = 3'(k);
    return idx;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Inverse segment lookup: lowest matching nibble wins, ambig flags a second match.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic             hit,
  output logic             ambig,
  output logic [NIB_W-1:0] nibble
);

  always_comb begin
    hit    = 1'b0;
    ambig  = 1'b0;
    nibble = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_CODE[i]) begin
        if (hit) ambig = 1'b1;
        else begin
          hit    = 1'b1;
          nibble = NIB_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/seg_bus_capture.sv
// Recovers per-digit nibbles from a multiplexed seven-segment bus after a stability window.
// Optional frame-complete pulse enabled by SEGCAP_FRAME_EN.
//
// state  | meaning
// IDLE   | dig_sel zero or not one-hot, nothing tracked
// TRACK  | counting consecutive identical samples of one digit
// LOCKED | current sample already captured, waiting for a change
module seg_bus_capture
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CYC = 4,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEG_W-1:0]        seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    upd,
  output logic [2:0]              upd_idx,
  output logic                    err,
  output logic                    ambig
`ifdef SEGCAP_FRAME_EN
  ,
  output logic                    frame_done
`endif
);

  fsm_state_t            state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx, cnt_inc;
  logic [SEG_W-1:0]      last_seg;
  logic [NUM_DIGITS-1:0] last_sel;
  logic                  legal, changed, done, load, capture;
  logic                  dec_hit, dec_ambig;
  logic [NIB_W-1:0]      dec_nib;

  assign legal   = onehot_legal(8'(dig_sel));
  assign changed = (dig_sel != last_sel) || (seg != last_seg);
  assign cnt_inc = cnt + CNT_W'(1);
  assign done    = (cnt_inc == CNT_W'(STABLE_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last_seg <= '0;
      last_sel <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (load) begin
        last_seg <= seg;
        last_sel <= dig_sel;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (legal) state_nx = TRACK;
      TRACK: begin
        if (!legal)                state_nx = IDLE;
        else if (!changed && done) state_nx = LOCKED;
      end
      LOCKED: begin
        if (!legal)       state_nx = IDLE;
        else if (changed) state_nx = TRACK;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    capture = 1'b0;
    cnt_nx  = cnt;
    if (state == IDLE || !legal) begin
      cnt_nx = '0;
      if (state == IDLE && legal) begin
        load   = 1'b1;
        cnt_nx = CNT_W'(1);
      end
    end else if (changed) begin
      load   = 1'b1;
      cnt_nx = CNT_W'(1);
    end else if (state == TRACK) begin
      cnt_nx  = cnt_inc;
      capture = done;
    end
  end

  // At a capture edge seg equals last_seg, so decode the registered copy.
  seg_pattern_decode u_dec (
    .seg    (last_seg),
    .hit    (dec_hit),
    .ambig  (dec_ambig),
    .nibble (dec_nib)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value       <= '0;
      digit_valid <= '0;
      upd         <= 1'b0;
      upd_idx     <= '0;
      err         <= 1'b0;
      ambig       <= 1'b0;
    end else begin
      upd <= capture;
      if (capture) begin
        upd_idx <= sel_index(8'(last_sel));
        err     <= !dec_hit;
        ambig   <= dec_ambig;
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (last_sel[k] && dec_hit) begin
            value[4*k +: 4] <= dec_nib;
            digit_valid[k]  <= 1'b1;
          end
        end
      end
    end
  end

`ifdef SEGCAP_FRAME_EN
  logic [NUM_DIGITS-1:0] seen, seen_nx;

  assign seen_nx = seen | (dec_hit ? last_sel : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (capture) begin
        if (&seen_nx) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen_nx;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_seg_bus_capture.sv
// Randomized and directed bench for seg_bus_capture against a run-length reference model.
module tb_seg_bus_capture;
  import seg_pkg::*;

  localparam int ND = 4;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = '0;
  logic [3:0]  dig_sel = '0;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        upd;
  logic [2:0]  upd_idx;
  logic        err;
  logic        ambig;
  logic        frame_done;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: a capture happens on the SC-th consecutive identical legal sample.
  logic [3:0]  p_sel;
  logic [6:0]  p_seg;
  int          run;
  logic [15:0] m_value;
  logic [3:0]  m_valid, m_seen;
  logic        m_upd, m_err, m_ambig, m_frame;
  logic [2:0]  m_idx;

  seg_bus_capture #(.NUM_DIGITS(ND), .STABLE_CYC(SC), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .dig_sel     (dig_sel),
    .value       (value),
    .digit_valid (digit_valid),
    .upd         (upd),
    .upd_idx     (upd_idx),
    .err         (err),
    .ambig       (ambig)
`ifdef SEGCAP_FRAME_EN
    ,
    .frame_done  (frame_done)
`endif
  );

`ifndef SEGCAP_FRAME_EN
  assign frame_done = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    p_sel = '0; p_seg = '0; run = 0;
    m_value = '0; m_valid = '0; m_seen = '0;
    m_upd = 0; m_err = 0; m_ambig = 0; m_frame = 0; m_idx = '0;
  endtask

  task automatic model_edge(input logic [3:0] sel, input logic [6:0] sg);
    int hits, nib, idx;
    bit legal;
    legal = ($countones(sel) == 1);
    if (legal && run > 0 && sel == p_sel && sg == p_seg) run++;
    else run = legal ? 1 : 0;
    p_sel = sel; p_seg = sg;
    m_upd = 0; m_frame = 0;
    if (run == SC) begin
      hits = 0; nib = 0; idx = 0;
      for (int i = 15; i >= 0; i--)
        if (sg == SEG_CODE[i]) begin hits++; nib = i; end
      for (int k = 0; k < ND; k++) if (sel[k]) idx = k;
      m_upd = 1; m_idx = 3'(idx);
      m_err = (hits == 0); m_ambig = (hits > 1);
      if (hits > 0) begin
        m_value[4*idx +: 4] = 4'(nib);
        m_valid[idx] = 1'b1;
        m_seen[idx] = 1'b1;
        if (&m_seen) begin m_frame = 1; m_seen = '0; end
      end
    end
  endtask

  task automatic check_all();
    chk("upd", 32'(upd), 32'(m_upd));
    chk("upd_idx", 32'(upd_idx), 32'(m_idx));
    chk("value", 32'(value), 32'(m_value));
    chk("digit_valid", 32'(digit_valid), 32'(m_valid));
    chk("err", 32'(err), 32'(m_err));
    chk("ambig", 32'(ambig), 32'(m_ambig));
`ifdef SEGCAP_FRAME_EN
    chk("frame_done", 32'(frame_done), 32'(m_frame));
`endif
  endtask

  task automatic step(input logic [3:0] sel, input logic [6:0] sg, input int n);
    repeat (n) begin
      @(negedge clk);
      dig_sel = sel; seg = sg;
      @(posedge clk);
      model_edge(sel, sg);
      #1 check_all();
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_value"}, 32'(value), 0);
    chk({tag, "_valid"}, 32'(digit_valid), 0);
    chk({tag, "_upd"}, 32'(upd), 0);
    chk({tag, "_idx"}, 32'(upd_idx), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_ambig"}, 32'(ambig), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero(tag);
    model_reset();
    dig_sel = '0; seg = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] sel;
    logic [6:0] pat;
    int r;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("rst_init");
    rst_n = 1'b1;

    // Digit 1 shows a 5.
    step(4'b0010, 7'b1001010, 4);
    chk("d5_upd", 32'(upd), 1);
    chk("d5_value", 32'(value[7:4]), 5);
    chk("d5_valid", 32'(digit_valid), 32'b0010);
    chk("d5_idx", 32'(upd_idx), 1);
    chk("d5_err_ambig", {30'd0, err, ambig}, 0);
    step(4'b0010, 7'b1001010, 3);
    chk("d5_locked_noupd", 32'(upd), 0);

    // Interrupted stability window on digit 3, then a full one.
    step(4'b1000, 7'b0010101, 3);
    step(4'b1000, 7'b1011011, 1);
    step(4'b1000, 7'b0010101, 3);
    chk("f_early_noupd", 32'(upd), 0);
    step(4'b1000, 7'b0010101, 1);
    chk("f_upd", 32'(upd), 1);
    chk("f_value", 32'(value[15:12]), 15);

    step(4'b0001, 7'b1111111, 4);
    chk("amb_value", 32'(value[3:0]), 0);
    chk("amb_flag", 32'(ambig), 1);
    chk("amb_err", 32'(err), 0);

    step(4'b0100, 7'b0000000, 4);
    chk("err_upd", 32'(upd), 1);
    chk("err_flag", 32'(err), 1);
    chk("err_valid2", 32'(digit_valid[2]), 0);
    chk("err_idx", 32'(upd_idx), 2);

    step(4'b0110, 7'b1001111, 10);
    chk("illegal_noupd", 32'(upd), 0);

    // Reset with the counter at 3.
    step(4'b0001, 7'b0000110, 3);
    do_reset("rst_track");
    step(4'b0001, 7'b0000110, 3);
    chk("post_rst_noupd", 32'(upd), 0);
    step(4'b0001, 7'b0000110, 1);
    chk("post_rst_upd", 32'(upd), 1);
    chk("post_rst_value", 32'(value[3:0]), 1);

    do_reset("rst_frame");
    for (int pass = 0; pass < 2; pass++) begin
      for (int d = 0; d < ND; d++) begin
        sel = 4'(1 << d);
        step(sel, SEG_CODE[d + 2 + 4 * pass], SC);
      end
`ifdef SEGCAP_FRAME_EN
      chk("frame_pulse", 32'(frame_done), 1);
`endif
      step(4'b0000, 7'b0, 2);
    end

    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) sel = 4'b0000;
      else if (r == 1) sel = 4'b0011 << $urandom_range(0, 2);
      else sel = 4'(1 << $urandom_range(0, 3));
      r = $urandom_range(0, 19);
      if (r < 16) pat = SEG_CODE[r];
      else if (r == 16) pat = 7'b0000000;
      else pat = 7'($urandom);
      step(sel, pat, $urandom_range(1, 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
